// File: rtl/adc_capture_multi.sv
// Lock-stepped multi-lane SPI ADC capture engine.
// Each conversion word is buffered in a first-word-fall-through FIFO.
module adc_capture_multi #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NCH        = 2,
    parameter int unsigned CLKDIV     = 2,
    parameter int unsigned CS_HIGH    = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned NSAMP_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NSAMP_W-1:0]       nsamp,
    input  logic [NCH-1:0]           miso,
    output logic                     sclk,
    output logic                     cs,
    output logic [NCH*DATA_W-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int unsigned CMAX  = (2 * CLKDIV > CS_HIGH) ? 2 * CLKDIV : CS_HIGH;
    localparam int unsigned CNT_W = $clog2(CMAX);
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned WW    = NCH * DATA_W;

    localparam logic [CNT_W-1:0] SetupLast = CNT_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] BitHalf   = CNT_W'(CLKDIV);
    localparam logic [CNT_W-1:0] BitLast   = CNT_W'(2 * CLKDIV - 1);
    localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(CS_HIGH - 1);
    localparam logic [BIT_W-1:0] LastBit   = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cyc_q, cyc_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic [NSAMP_W-1:0]         left_q, left_d;
    logic                       ovf_q, ovf_d;
    logic                       cs_q, cs_d, sclk_q, sclk_d;
    logic                       push, sample;
    logic [NCH-1:0][DATA_W-1:0] sh_q;

    logic [WW-1:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]              wptr_q, rptr_q;
    logic [AW:0]                cnt_q;
    logic                       full, pop, wr_en;

    assign full     = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    assign m_valid  = (cnt_q != '0);
    assign pop      = m_valid & m_ready;
    assign wr_en    = push & (~full | pop);
    assign m_data   = mem[rptr_q];
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign overflow = ovf_q;
    assign cs       = cs_q;
    assign sclk     = sclk_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        left_d  = left_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        sample  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ovf_d = 1'b0;
                    cyc_d = '0;
                    if (nsamp != '0) begin
                        left_d  = nsamp;
                        state_d = StSetup;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSetup: begin
                if (cyc_q == SetupLast) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = StShift;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StShift: begin
                // Lanes are sampled on the edge where sclk rises.
                sample = (cyc_q == SetupLast);
                if (cyc_q == BitLast) begin
                    cyc_d = '0;
                    if (bit_q == LastBit) state_d = StHold;
                    else                  bit_d   = bit_q + 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StHold: begin
                push = (cyc_q == '0);
                if (cyc_q == HoldLast) begin
                    cyc_d   = '0;
                    left_d  = left_q - 1'b1;
                    state_d = (left_q == NSAMP_W'(1)) ? StDone : StSetup;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (push && full && !pop) ovf_d = 1'b1;
        // cs/sclk are registered from next state so the ADC sees glitch-free lines.
        cs_d   = !(state_d == StSetup || state_d == StShift);
        sclk_d = !(state_d == StShift && cyc_d < BitHalf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            bit_q   <= '0;
            left_q  <= '0;
            ovf_q   <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            left_q  <= left_d;
            ovf_q   <= ovf_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            if (sample) begin
                for (int i = 0; i < NCH; i++) begin
                    sh_q[i] <= (sh_q[i] << 1) | DATA_W'(miso[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (pop)   rptr_q <= rptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= sh_q;
    end

endmodule

// File: tb/tb_adc_capture_multi.sv
// Directed bench for adc_capture_multi at default parameters.
// A behavioural ADC shifts per-conversion words out on falling sclk.
module tb_adc_capture_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] nsamp = '0;
    logic [1:0]  miso = '0;
    logic        m_ready = 1'b0;
    logic        sclk, cs, m_valid, busy, done, overflow;
    logic [15:0] m_data;

    adc_capture_multi dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .nsamp    (nsamp),
        .miso     (miso),
        .sclk     (sclk),
        .cs       (cs),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ADC model: word {lane1, lane0} per conversion, indexed by cs falling edges.
    logic [15:0] adc_words [128];
    int          conv_k = 0;
    int          bit_i  = 0;
    logic [15:0] cur_w  = '0;

    always @(negedge cs or negedge sclk) begin
        if (!cs && sclk) begin
            cur_w  = adc_words[conv_k & 127];
            conv_k = conv_k + 1;
            bit_i  = 0;
        end else if (!cs && !sclk && bit_i < 8) begin
            miso[0] = cur_w[7 - bit_i];
            miso[1] = cur_w[15 - bit_i];
            bit_i   = bit_i + 1;
        end
    end

    int          cs_low_cnt = 0;
    int          sclk_rise  = 0;
    logic [15:0] got_q [$];

    always @(negedge clk) if (!cs) cs_low_cnt++;
    always @(posedge sclk) if (!cs) sclk_rise++;
    always @(negedge clk) if (m_valid && m_ready) got_q.push_back(m_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        tick();
        nsamp = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle index of the done pulse, counted from the start cycle.
    task automatic wait_done(input int first, input int budget, output int cyc);
        cyc = first;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    function automatic logic [15:0] w2(input int j);
        return {8'(8'hF0 - j), 8'(8'h10 + j)};
    endfunction
    function automatic logic [15:0] w3(input int j);
        return {8'(j * 3), 8'(8'hC0 + j)};
    endfunction
    function automatic logic [15:0] w4(input int j);
        return {8'(8'h20 + j), 8'(8'h70 + j)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, g0, cl0, sr0, rises;
        logic prev_cs;

        repeat (3) tick();
        check("rst_cs", 32'(cs), 1);
        check("rst_sclk", 32'(sclk), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_valid", 32'(m_valid), 0);
        reset = 1'b0;
        tick();

        // Single conversion, A5/3C.
        adc_words[conv_k & 127] = 16'h3CA5;
        cl0 = cs_low_cnt;
        sr0 = sclk_rise;
        do_start(1);
        wait_done(1, 100, c);
        check("t1_done_cyc", 32'(c), 39);
        check("t1_cs_low", 32'(cs_low_cnt - cl0), 34);
        check("t1_sclk_rises", 32'(sclk_rise - sr0), 8);
        check("t1_valid", 32'(m_valid), 1);
        check("t1_data", 32'(m_data), 32'h3CA5);
        check("t1_cs_high", 32'(cs), 1);
        check("t1_busy_at_done", 32'(busy), 1);
        tick();
        check("t1_done_pulse", 32'(done), 0);
        check("t1_busy_fall", 32'(busy), 0);
        m_ready = 1'b1;
        tick();
        check("t1_popped", 32'(m_valid), 0);

        // Five conversions streamed out with m_ready held high.
        for (int j = 0; j < 5; j++) adc_words[(conv_k + j) & 127] = w2(j);
        g0 = got_q.size();
        do_start(5);
        wait_done(1, 400, c);
        check("t2_done_cyc", 32'(c), 1 + 5 * 38);
        check("t2_ovf", 32'(overflow), 0);
        repeat (2) tick();
        check("t2_count", 32'(got_q.size() - g0), 5);
        for (int j = 0; j < 5; j++)
            if (g0 + j < got_q.size()) check("t2_word", 32'(got_q[g0 + j]), 32'(w2(j)));

        // Twelve conversions into an undrained FIFO: first eight kept.
        m_ready = 1'b0;
        for (int j = 0; j < 12; j++) adc_words[(conv_k + j) & 127] = w3(j);
        do_start(12);
        wait_done(1, 600, c);
        check("t3_done_cyc", 32'(c), 1 + 12 * 38);
        check("t3_ovf", 32'(overflow), 1);
        check("t3_valid", 32'(m_valid), 1);
        check("t3_head", 32'(m_data), 32'(w3(0)));
        g0 = got_q.size();
        m_ready = 1'b1;
        repeat (10) tick();
        m_ready = 1'b0;
        check("t3_drained", 32'(got_q.size() - g0), 8);
        for (int j = 0; j < 8; j++)
            if (g0 + j < got_q.size()) check("t3_word", 32'(got_q[g0 + j]), 32'(w3(j)));
        check("t3_empty", 32'(m_valid), 0);

        // Ninth push lands on a full FIFO together with a pop: nothing lost.
        for (int j = 0; j < 9; j++) adc_words[(conv_k + j) & 127] = w4(j);
        do_start(9);
        rises   = 0;
        prev_cs = cs;
        for (int t = 0; t < 500 && rises < 9; t++) begin
            tick();
            if (cs && !prev_cs) rises++;
            prev_cs = cs;
        end
        check("t4_push_seen", 32'(rises), 9);
        g0 = got_q.size();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t4_popped_one", 32'(got_q.size() - g0), 1);
        if (got_q.size() > g0) check("t4_pop_word", 32'(got_q[g0]), 32'(w4(0)));
        wait_done(0, 100, c);
        check("t4_done", 32'(done), 1);
        check("t4_ovf", 32'(overflow), 0);
        check("t4_head", 32'(m_data), 32'(w4(1)));
        g0 = got_q.size();
        m_ready = 1'b1;
        repeat (10) tick();
        check("t4_drained", 32'(got_q.size() - g0), 8);
        for (int j = 0; j < 8; j++)
            if (g0 + j < got_q.size()) check("t4_word", 32'(got_q[g0 + j]), 32'(w4(j + 1)));

        // Start while busy is ignored; nsamp==0 gives an immediate done.
        adc_words[conv_k & 127] = 16'h1234;
        g0 = got_q.size();
        do_start(1);
        repeat (5) tick();
        nsamp = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(7, 100, c);
        check("t5_done_cyc", 32'(c), 39);
        tick();
        check("t5_not_restarted", 32'(busy), 0);
        repeat (3) tick();
        check("t5_one_word", 32'(got_q.size() - g0), 1);
        if (got_q.size() > g0) check("t5_word", 32'(got_q[g0]), 32'h1234);
        cl0 = cs_low_cnt;
        do_start(0);
        wait_done(1, 10, c);
        check("t5_zero_done_cyc", 32'(c), 1);
        tick();
        check("t5_zero_busy", 32'(busy), 0);
        check("t5_zero_cs", 32'(cs_low_cnt - cl0), 0);

        // Asynchronous reset in the middle of the second conversion's shift.
        m_ready = 1'b0;
        adc_words[conv_k & 127]       = 16'h0F0F;
        adc_words[(conv_k + 1) & 127] = 16'hF0F0;
        do_start(2);
        repeat (50) tick();
        check("t6_pre_valid", 32'(m_valid), 1);
        check("t6_pre_cs", 32'(cs), 0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_cs", 32'(cs), 1);
        check("t6_sclk", 32'(sclk), 1);
        check("t6_valid", 32'(m_valid), 0);
        check("t6_busy", 32'(busy), 0);
        tick();
        reset = 1'b0;
        adc_words[conv_k & 127] = 16'hBEEF;
        m_ready = 1'b1;
        g0 = got_q.size();
        do_start(1);
        wait_done(1, 100, c);
        check("t6_done_cyc", 32'(c), 39);
        check("t6_ovf", 32'(overflow), 0);
        repeat (2) tick();
        check("t6_one_word", 32'(got_q.size() - g0), 1);
        if (got_q.size() > g0) check("t6_word", 32'(got_q[g0]), 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
